bitrev_frame_ctrl: RTL



---
 rtl/bitrev_pkg.sv | 33 +++
 rtl/bitrev_frame_ctrl_decode.sv | 21 ++
 rtl/bitrev_frame_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
`default_nettype none
// ============================================================================
// bitrev_pkg : shared constants, state encoding and bit-reverse helper
// Revision 1.0
// ============================================================================
package bitrev_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_ONE  = 8'h31;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHAR = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t OUTPUT  = 2'd2;

  // Word of width i_w sits in the LSBs; result is reversed within those i_w bits.
  function automatic logic [15:0] bit_reverse(input logic [15:0] i_word, input int i_w);
    logic [15:0] w_rev;
    for (int i = 0; i < 16; i++) begin
      w_rev[i] = i_word[15-i];
    end
    return w_rev >> (16 - i_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_frame_ctrl_decode.sv
`default_nettype none
// ============================================================================
// ascii_bit_decode : classifies one ASCII character as data / filler / illegal
// Revision 1.0
// ============================================================================
module ascii_bit_decode (
  input  logic [7:0] i_char,
  output logic       o_is_data,
  output logic       o_is_filler,
  output logic       o_is_illegal,
  output logic       o_bit_val
);
  import bitrev_pkg::*;

  assign o_is_data    = (i_char == CH_ZERO) || (i_char == CH_ONE);
  assign o_is_filler  = (i_char == CH_SP) || (i_char == CH_CR) || (i_char == CH_LF);
  assign o_is_illegal = !(o_is_data || o_is_filler);
  assign o_bit_val    = (i_char == CH_ONE);

endmodule
`default_nettype wire

// File: rtl/bitrev_frame_ctrl.sv
`default_nettype none
// ============================================================================
// bitrev_frame_ctrl : assembles W ASCII bits MSB-first, emits (reversed) word
// Revision 1.0
// ============================================================================
module bitrev_frame_ctrl #(
  parameter int W       = 8,
  parameter bit REVERSE = 1'b1,
  parameter int TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  output logic [W-1:0]         byte_out,
  output logic                 byte_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [$clog2(W)-1:0] bit_pos
);
  import bitrev_pkg::*;

  localparam int c_PW = $clog2(W);
  localparam int c_TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_PW-1:0] c_LAST_POS = c_PW'(W - 1);

  state_t          r_state;
  logic [W-1:0]    r_asm;
  logic [W-1:0]    r_byte_out;
  logic [c_PW-1:0] r_bit_pos;
  logic            r_valid;
  logic            r_err;
  logic [1:0]      r_err_code;

  logic            w_is_data;
  logic            w_is_filler;
  logic            w_is_illegal;
  logic            w_bit_val;
  logic [2:0]      w_class;
  logic            w_ready;
  logic            w_acc_data;
  logic            w_acc_filler;
  logic            w_acc_illegal;
  logic            w_tmo_expire;
  logic [W-1:0]    w_asm_next;
  logic [W-1:0]    w_word_out;

  ascii_bit_decode u_decode (
    .i_char       (char_in),
    .o_is_data    (w_is_data),
    .o_is_filler  (w_is_filler),
    .o_is_illegal (w_is_illegal),
    .o_bit_val    (w_bit_val)
  );

  // Decoder classes are one-hot; match the full pattern so a bad decode is never accepted as data.
  assign w_class       = {w_is_data, w_is_filler, w_is_illegal};
  assign w_ready       = (r_state != OUTPUT);
  assign w_acc_data    = char_valid & w_ready & (w_class == 3'b100);
  assign w_acc_filler  = char_valid & w_ready & (w_class == 3'b010);
  assign w_acc_illegal = char_valid & w_ready & (w_class == 3'b001);

  // A fresh frame starts from a clean word; otherwise merge the new bit into the partial word.
  always_comb begin
    w_asm_next = (r_state == IDLE) ? '0 : r_asm;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1 - int'(r_bit_pos)) begin
        w_asm_next[i] = w_bit_val;
      end
    end
  end

  generate
    if (REVERSE) begin : g_rev
      assign w_word_out = W'(bit_reverse(16'(w_asm_next), W));
    end else begin : g_straight
      assign w_word_out = w_asm_next;
    end
  endgenerate

  // Filler neither restarts nor advances the idle count; a data char on the expiry cycle wins.
  generate
    if (TIMEOUT > 0) begin : g_tmo
      logic [c_TW-1:0] r_tmo;

      assign w_tmo_expire = (r_state == COLLECT) && !w_acc_data && !w_acc_illegal &&
                            !w_acc_filler && (r_tmo == c_TW'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_tmo <= '0;
        end else if ((r_state != COLLECT) || w_acc_data || w_acc_illegal || w_tmo_expire) begin
          r_tmo <= '0;
        end else if (!w_acc_filler) begin
          r_tmo <= r_tmo + c_TW'(1);
        end
      end
    end else begin : g_no_tmo
      assign w_tmo_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_asm      <= '0;
      r_byte_out <= '0;
      r_bit_pos  <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc_data) begin
            r_asm     <= w_asm_next;
            r_bit_pos <= c_PW'(1);
            r_state   <= COLLECT;
          end else if (w_acc_illegal) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_CHAR;
          end
        end
        COLLECT: begin
          if (w_acc_data) begin
            r_asm <= w_asm_next;
            if (r_bit_pos == c_LAST_POS) begin
              r_byte_out <= w_word_out;
              r_valid    <= 1'b1;
              r_bit_pos  <= '0;
              r_state    <= OUTPUT;
            end else begin
              r_bit_pos <= r_bit_pos + c_PW'(1);
            end
          end else if (w_acc_illegal) begin
            r_bit_pos  <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_CHAR;
            r_state    <= IDLE;
          end else if (w_tmo_expire) begin
            r_bit_pos  <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= IDLE;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign char_ready = w_ready;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_valid;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign bit_pos    = r_bit_pos;

endmodule
`default_nettype wire
